soin_bpredictor_resolve: RTL and testbench
==========================================

SOIN_BPREDICTOR_RESOLVE -- requirements
Module: soin_bpredictor_resolve

Interface
REQ-001 Parameters SHALL be: Q_DEPTH, default 4, update-queue entries (power of 2); SQUASH_CYCLES, default 2, cycles execute results are ignored after a miss.
REQ-002 Ports SHALL be:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute has a resolved instruction this cycle.
- ex_is_branch  in  1  instruction is a control transfer.
- ex_PC  in  32  instruction PC.
- ex_taken  in  1  actual direction.
- ex_target  in  32  actual target.
- ex_p_dir  in  1  predicted direction carried down the pipe.
- ex_p_target  in  32  predicted next PC carried down the pipe.
- ex_meta  in  `BP_META_WIDTH  predictor meta (RAS index).
- soin_bpredictor_stall  in  1  predictor cannot accept an update.
- fetch_redirect  out  1  redirect fetch.
- fetch_redirect_PC  out  32  correct next PC.
- execute_bpredictor_update, _dir, _miss, _recover_ras  out  1 each  update strobe and fields.
- execute_bpredictor_PC, _target  out  32 each.
- execute_bpredictor_meta  out  `BP_META_WIDTH.
- soin_bpredictor_debug_sel  in  32  debug select.
- bpredictor_soin_debug  out  32  debug read data.

Function
REQ-003 A resolved branch SHALL be accepted when ex_valid & ex_is_branch and the FSM is in RUN.
REQ-004 miss SHALL be (ex_p_dir != ex_taken) | (ex_taken & (ex_p_target != ex_target)).
REQ-005 Correct next PC SHALL be ex_target if ex_taken, else ex_PC + 4 (32-bit wrap).
REQ-006 On an accepted miss, fetch_redirect SHALL pulse 1 for exactly one cycle, one cycle after acceptance, carrying the correct next PC; otherwise it SHALL be 0.
REQ-007 FSM states SHALL be RUN and SQUASH; RUN -> SQUASH on an accepted miss; SQUASH lasts SQUASH_CYCLES cycles, then -> RUN; in SQUASH all ex_valid inputs are ignored.
REQ-008 Each accepted branch SHALL push {PC, correct next PC, taken, miss, miss, meta} into a Q_DEPTH FIFO; recover_ras equals miss.
REQ-009 execute_bpredictor_update SHALL equal (queue non-empty) & ~soin_bpredictor_stall; the head entry SHALL drive the data outputs; the head pops in any cycle update is 1.
REQ-010 Update latency SHALL be one cycle minimum (push at edge N, update asserted in cycle N+1 when unstalled); updates SHALL issue in acceptance order.
REQ-011 Simultaneous push and pop SHALL be allowed, including when full; occupancy is unchanged.
REQ-012 Push when full without a pop SHALL drop the new entry, still apply REQ-006/007, and set a sticky overflow flag.
REQ-013 Data outputs while update is 0 SHALL hold the head entry (don't-care when empty, driven 0).
REQ-014 bpredictor_soin_debug SHALL return {occupancy, overflow flag} in low bits for debug_sel 0, else 0 (see REQ-018).

Reset
REQ-015 Asserting reset SHALL asynchronously empty the queue, clear the overflow flag, force the FSM to RUN, and drive all outputs to 0.
REQ-016 Reset mid-SQUASH or with a pending redirect SHALL cancel both; no redirect or update issues after release until new input.

Configuration
REQ-017 Macro BPRED_STATS_EN SHALL compile in two 32-bit saturating counters: accepted branches and accepted misses.
REQ-018 With BPRED_STATS_EN, debug_sel 1 and 2 SHALL return the branch and miss counters, cleared by reset; without it, they return 0 and no counter flops exist.

Structure
REQ-019 Shared package SHALL hold BP_META_WIDTH, the FSM state encoding, and the queue-entry field layout.
REQ-020 The FIFO SHALL be a sub-module soin_bpredictor_uq (parameterised depth/width); FSM, compare and stats stay at top level.

Verification
REQ-021 Correct prediction: PC 0x100, taken, target 0x200, p_dir 1, p_target 0x200 -> no redirect; next cycle update=1, PC 0x100, dir 1, miss 0.
REQ-022 Direction miss: PC 0x100, not taken, p_dir 1 -> redirect 0x104 one cycle later; update miss=1, recover_ras=1, meta echoed.
REQ-023 Squash: miss followed by two valid branches on consecutive cycles -> both ignored, no pushes; third branch accepted.
REQ-024 Stall: stall=1 for 6 cycles with 5 branch inputs -> 4 queued, 5th dropped, overflow=1; release -> 4 updates in order.
REQ-025 Reset asserted during SQUASH with queue holding 2 entries -> outputs 0 immediately, occupancy 0, FSM RUN.
REQ-026 With BPRED_STATS_EN: 10 branches, 3 misses (squash-separated) -> debug_sel 1 reads 10, sel 2 reads 3.

Source files
------------

// File: rtl/soin_bpredictor_resolve_pkg.sv
// rtl/soin_bpredictor_resolve_pkg.sv - shared types and constants for branch resolve
package soin_bpredictor_resolve_pkg;

  localparam int BP_META_WIDTH = 4;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } bp_state_e;

  // One predictor update, oldest field in the MSBs
  typedef struct packed {
    logic [31:0]              pc;
    logic [31:0]              next_pc;
    logic                     taken;
    logic                     miss;
    logic                     recover_ras;
    logic [BP_META_WIDTH-1:0] meta;
  } uq_entry_t;

  localparam int UQ_ENTRY_W = $bits(uq_entry_t);

  // Architecturally correct fall-through or taken target
  function automatic logic [31:0] correct_next_pc(input logic [31:0] pc,
                                                  input logic        taken,
                                                  input logic [31:0] target);
    return taken ? target : (pc + 32'd4);
  endfunction

endpackage

// File: rtl/soin_bpredictor_uq.sv
// rtl/soin_bpredictor_uq.sv - predictor update queue with drop-on-full and sticky overflow
module soin_bpredictor_uq #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             pop_eff;
  logic             wr_en;
  logic             drop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_eff = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full queue can still take a push
  assign wr_en   = push & (~full | pop_eff);
  assign drop    = push & full & ~pop_eff;

  assign head_data = empty ? '0 : mem[rd_ptr];

  // Pointer, occupancy and sticky overflow tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // Entry storage; contents are qualified by count so no reset is needed
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/soin_bpredictor_resolve.sv
// rtl/soin_bpredictor_resolve.sv - branch resolve, fetch redirect and predictor update queue (option: BPRED_STATS_EN)
module soin_bpredictor_resolve
  import soin_bpredictor_resolve_pkg::*;
#(
  parameter int Q_DEPTH       = 4,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ex_valid,
  input  logic                     ex_is_branch,
  input  logic [31:0]              ex_PC,
  input  logic                     ex_taken,
  input  logic [31:0]              ex_target,
  input  logic                     ex_p_dir,
  input  logic [31:0]              ex_p_target,
  input  logic [BP_META_WIDTH-1:0] ex_meta,
  input  logic                     soin_bpredictor_stall,
  output logic                     fetch_redirect,
  output logic [31:0]              fetch_redirect_PC,
  output logic                     execute_bpredictor_update,
  output logic                     execute_bpredictor_dir,
  output logic                     execute_bpredictor_miss,
  output logic                     execute_bpredictor_recover_ras,
  output logic [31:0]              execute_bpredictor_PC,
  output logic [31:0]              execute_bpredictor_target,
  output logic [BP_META_WIDTH-1:0] execute_bpredictor_meta,
  input  logic [31:0]              soin_bpredictor_debug_sel,
  output logic [31:0]              bpredictor_soin_debug
);

  localparam int SQ_W = (SQUASH_CYCLES > 2) ? $clog2(SQUASH_CYCLES) : 1;
  localparam int OCC_W = $clog2(Q_DEPTH) + 1;

  bp_state_e        state, state_nxt;
  logic [SQ_W-1:0]  sq_cnt, sq_cnt_nxt;
  logic             accept;
  logic             miss;
  logic [31:0]      next_pc;
  uq_entry_t        push_entry;
  uq_entry_t        head_entry;
  logic [UQ_ENTRY_W-1:0] head_bits;
  logic             uq_empty;
  logic [OCC_W-1:0] uq_count;
  logic             uq_overflow;
  logic             update;

  assign accept  = ex_valid & ex_is_branch & (state == ST_RUN);
  assign miss    = (ex_p_dir != ex_taken) | (ex_taken & (ex_p_target != ex_target));
  assign next_pc = correct_next_pc(ex_PC, ex_taken, ex_target);

  // FSM state register and squash countdown
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_RUN;
      sq_cnt <= '0;
    end else begin
      state  <= state_nxt;
      sq_cnt <= sq_cnt_nxt;
    end
  end

  // Next state: a miss opens a window in which younger execute results are wrong-path
  always_comb begin
    state_nxt  = state;
    sq_cnt_nxt = sq_cnt;
    case (state)
      ST_RUN: begin
        if (accept && miss) begin
          state_nxt  = ST_SQUASH;
          sq_cnt_nxt = SQ_W'(SQUASH_CYCLES - 1);
        end
      end
      ST_SQUASH: begin
        if (sq_cnt == '0) state_nxt = ST_RUN;
        else              sq_cnt_nxt = sq_cnt - 1'b1;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // One-cycle redirect pulse registered after the mispredicting branch is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_redirect    <= 1'b0;
      fetch_redirect_PC <= '0;
    end else begin
      fetch_redirect    <= accept & miss;
      fetch_redirect_PC <= (accept & miss) ? next_pc : '0;
    end
  end

  // Pack the resolved branch into a queue entry
  always_comb begin
    push_entry             = '0;
    push_entry.pc          = ex_PC;
    push_entry.next_pc     = next_pc;
    push_entry.taken       = ex_taken;
    push_entry.miss        = miss;
    push_entry.recover_ras = miss;
    push_entry.meta        = ex_meta;
  end

  assign update = ~uq_empty & ~soin_bpredictor_stall;

  soin_bpredictor_uq #(
    .DEPTH (Q_DEPTH),
    .WIDTH (UQ_ENTRY_W)
  ) u_uq (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (push_entry),
    .pop       (update),
    .head_data (head_bits),
    .empty     (uq_empty),
    .count     (uq_count),
    .overflow  (uq_overflow)
  );

  assign head_entry = uq_entry_t'(head_bits);

  assign execute_bpredictor_update      = update;
  assign execute_bpredictor_dir         = head_entry.taken;
  assign execute_bpredictor_miss        = head_entry.miss;
  assign execute_bpredictor_recover_ras = head_entry.recover_ras;
  assign execute_bpredictor_PC          = head_entry.pc;
  assign execute_bpredictor_target      = head_entry.next_pc;
  assign execute_bpredictor_meta        = head_entry.meta;

`ifdef BPRED_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_misses;

  // Saturating counters of accepted branches and accepted misses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_branches <= '0;
      stat_misses   <= '0;
    end else begin
      if (accept && (stat_branches != '1)) stat_branches <= stat_branches + 32'd1;
      if (accept && miss && (stat_misses != '1)) stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

  // Debug read mux
  always_comb begin
    bpredictor_soin_debug = '0;
    case (soin_bpredictor_debug_sel)
      32'd0: bpredictor_soin_debug = 32'({uq_count, uq_overflow});
`ifdef BPRED_STATS_EN
      32'd1: bpredictor_soin_debug = stat_branches;
      32'd2: bpredictor_soin_debug = stat_misses;
`endif
      default: bpredictor_soin_debug = '0;
    endcase
  end

endmodule

// File: tb/tb_soin_bpredictor_resolve.sv
// tb/tb_soin_bpredictor_resolve.sv - scoreboard bench for soin_bpredictor_resolve
module tb_soin_bpredictor_resolve;
  import soin_bpredictor_resolve_pkg::*;

  localparam int QD = 4;
  localparam int SC = 2;
  localparam int MW = BP_META_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          ex_valid, ex_is_branch, ex_taken, ex_p_dir;
  logic [31:0]   ex_PC, ex_target, ex_p_target;
  logic [MW-1:0] ex_meta;
  logic          stall;
  logic          fetch_redirect;
  logic [31:0]   fetch_redirect_PC;
  logic          upd, upd_dir, upd_miss, upd_ras;
  logic [31:0]   upd_pc, upd_target;
  logic [MW-1:0] upd_meta;
  logic [31:0]   dbg_sel, dbg;

  soin_bpredictor_resolve #(.Q_DEPTH(QD), .SQUASH_CYCLES(SC)) dut (
    .clk                            (clk),
    .reset                          (reset),
    .ex_valid                       (ex_valid),
    .ex_is_branch                   (ex_is_branch),
    .ex_PC                          (ex_PC),
    .ex_taken                       (ex_taken),
    .ex_target                      (ex_target),
    .ex_p_dir                       (ex_p_dir),
    .ex_p_target                    (ex_p_target),
    .ex_meta                        (ex_meta),
    .soin_bpredictor_stall          (stall),
    .fetch_redirect                 (fetch_redirect),
    .fetch_redirect_PC              (fetch_redirect_PC),
    .execute_bpredictor_update      (upd),
    .execute_bpredictor_dir         (upd_dir),
    .execute_bpredictor_miss        (upd_miss),
    .execute_bpredictor_recover_ras (upd_ras),
    .execute_bpredictor_PC          (upd_pc),
    .execute_bpredictor_target      (upd_target),
    .execute_bpredictor_meta        (upd_meta),
    .soin_bpredictor_debug_sel      (dbg_sel),
    .bpredictor_soin_debug          (dbg)
  );

  typedef struct {
    logic [31:0]   pc;
    logic [31:0]   npc;
    logic          tk;
    logic          miss;
    logic [MW-1:0] meta;
  } ent_t;

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } red_t;

  typedef struct {
    logic        upd;
    int          occ;
    logic [31:0] dbg;
  } cyc_t;

  ent_t q_upd[$];
  red_t q_red[$];
  cyc_t q_cyc[$];

  int occ = 0;
  int sq_left = 0;
  bit ovf = 0;
  int st_br = 0;
  int st_miss = 0;
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] dbg_exp(input logic [31:0] sel);
    if (sel == 32'd0) return 32'((occ << 1) | int'(ovf));
`ifdef BPRED_STATS_EN
    if (sel == 32'd1) return 32'(st_br);
    if (sel == 32'd2) return 32'(st_miss);
`endif
    return 32'd0;
  endfunction

  // Drive one cycle of inputs and advance the reference model
  task automatic step(input logic v, input logic br, input logic [31:0] pc,
                      input logic tk, input logic [31:0] tg, input logic pd,
                      input logic [31:0] pt, input logic [MW-1:0] meta,
                      input logic st, input logic [31:0] sel);
    cyc_t ce;
    bit   pop, acc, m;
    ent_t e;
    red_t r;
    @(posedge clk); #1;
    ex_valid = v; ex_is_branch = br; ex_PC = pc; ex_taken = tk; ex_target = tg;
    ex_p_dir = pd; ex_p_target = pt; ex_meta = meta; stall = st; dbg_sel = sel;
    ce.occ = occ;
    ce.dbg = dbg_exp(sel);
    pop = (occ > 0) && !st;
    ce.upd = pop;
    q_cyc.push_back(ce);
    acc = v && br && (sq_left == 0);
    m = (pd != tk) || (tk && (pt != tg));
    if (pop) occ--;
    if (acc) begin
      if (occ < QD) begin
        e.pc = pc; e.npc = tk ? tg : pc + 32'd4; e.tk = tk; e.miss = m; e.meta = meta;
        q_upd.push_back(e);
        occ++;
      end else begin
        ovf = 1;
      end
      st_br++;
      if (m) st_miss++;
    end
    if (sq_left > 0) sq_left--;
    if (acc && m) begin
      sq_left = SC;
      r.cyc = cyc + 1;
      r.pc = tk ? tg : pc + 32'd4;
      q_red.push_back(r);
    end
  endtask

  task automatic idle(input int n, input logic st, input logic [31:0] sel);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 32'h0, 0, 32'h0, '0, st, sel);
  endtask

  // Correctly predicted branch: taken with matching target, or not taken
  task automatic good(input logic [31:0] pc, input logic [MW-1:0] meta, input logic st);
    step(1, 1, pc, 1, pc + 32'h40, 1, pc + 32'h40, meta, st, 32'd0);
  endtask

  // Direction miss: predicted taken, actually falls through
  task automatic bad(input logic [31:0] pc, input logic [MW-1:0] meta, input logic st);
    step(1, 1, pc, 0, 32'h0, 1, pc + 32'h40, meta, st, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_redirect"}, fetch_redirect, 0);
    chk({tag, "_redirect_pc"}, fetch_redirect_PC, 0);
    chk({tag, "_update"}, upd, 0);
    chk({tag, "_upd_dir"}, upd_dir, 0);
    chk({tag, "_upd_miss"}, upd_miss, 0);
    chk({tag, "_upd_ras"}, upd_ras, 0);
    chk({tag, "_upd_pc"}, upd_pc, 0);
    chk({tag, "_upd_target"}, upd_target, 0);
    chk({tag, "_upd_meta"}, upd_meta, 0);
    chk({tag, "_debug"}, dbg, 0);
  endtask

  // Reset asserted mid-cycle while the FSM is squashing and a redirect is showing
  task automatic reset_mid();
    @(posedge clk); #2;
    chk("pre_rst_redirect", fetch_redirect, (q_red.size() > 0) ? 1 : 0);
    chk("pre_rst_occ", dbg, dbg_exp(32'd0));
    reset = 0;
    ex_valid = 0; stall = 0; dbg_sel = 0;
    #1;
    check_all_zero("midrst");
    q_upd.delete(); q_red.delete(); q_cyc.delete();
    occ = 0; ovf = 0; sq_left = 0; st_br = 0; st_miss = 0;
    @(negedge clk);
    reset = 1;
  endtask

  // Monitor: compare every cycle the bench has an expectation for
  initial begin
    cyc_t e;
    ent_t h;
    bit   exp_r;
    forever begin
      @(negedge clk);
      if (q_red.size() > 0 && q_red[0].cyc < cyc) begin
        n_vec++; n_err++;
        $display("FAIL redirect_missing: expected pc %0h at cycle %0d", q_red[0].pc, q_red[0].cyc);
        void'(q_red.pop_front());
      end
      if (q_cyc.size() > 0) begin
        e = q_cyc.pop_front();
        chk("update", upd, e.upd);
        chk("debug", dbg, e.dbg);
        if (e.upd) begin
          if (q_upd.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL update_data: got pc %0h expected no entry", upd_pc);
          end else begin
            h = q_upd.pop_front();
            chk("upd_pc", upd_pc, h.pc);
            chk("upd_target", upd_target, h.npc);
            chk("upd_dir", upd_dir, h.tk);
            chk("upd_miss", upd_miss, h.miss);
            chk("upd_ras", upd_ras, h.miss);
            chk("upd_meta", upd_meta, h.meta);
          end
        end else if (e.occ > 0 && q_upd.size() > 0) begin
          chk("hold_pc", upd_pc, q_upd[0].pc);
          chk("hold_target", upd_target, q_upd[0].npc);
        end else if (e.occ == 0) begin
          chk("empty_pc", upd_pc, 0);
          chk("empty_meta", upd_meta, 0);
        end
        exp_r = (q_red.size() > 0) && (q_red[0].cyc == cyc);
        chk("redirect", fetch_redirect, exp_r);
        if (exp_r) begin
          chk("redirect_pc", fetch_redirect_PC, q_red[0].pc);
          void'(q_red.pop_front());
        end else begin
          chk("redirect_pc_idle", fetch_redirect_PC, 0);
        end
      end
    end
  end

  initial begin
    logic [31:0] tgs [4];
    logic [31:0] pc, tg, pt;
    logic        tk, pd;
    tgs[0] = 32'h2000; tgs[1] = 32'h2004; tgs[2] = 32'h3000; tgs[3] = 32'hFFFF_FFFC;
    reset = 0;
    ex_valid = 0; ex_is_branch = 0; ex_PC = 0; ex_taken = 0; ex_target = 0;
    ex_p_dir = 0; ex_p_target = 0; ex_meta = 0; stall = 0; dbg_sel = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1;

    // Correct prediction, then a direction miss with meta echoed
    step(1, 1, 32'h100, 1, 32'h200, 1, 32'h200, 4'h3, 0, 32'd0);
    idle(3, 0, 32'd0);
    step(1, 1, 32'h100, 0, 32'h200, 1, 32'h200, 4'h9, 0, 32'd0);
    idle(4, 0, 32'd0);

    // Target miss followed by two squashed branches and one accepted
    step(1, 1, 32'h400, 1, 32'h800, 1, 32'h900, 4'h1, 0, 32'd0);
    good(32'h404, 4'h2, 0);
    good(32'h408, 4'h3, 0);
    good(32'h40C, 4'h4, 0);
    idle(4, 0, 32'd0);

    // Stall long enough to overflow the queue, then drain in order
    for (int i = 0; i < 5; i++) good(32'h1000 + 32'(i * 4), MW'(i), 1);
    idle(1, 1, 32'd0);
    idle(7, 0, 32'd0);

    // PC wrap at the top of the address space
    step(1, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 32'h10, 4'hA, 0, 32'd0);
    idle(4, 0, 32'd0);

    // Two entries queued, FSM squashing, then reset
    good(32'h5000, 4'h5, 1);
    bad(32'h5004, 4'h6, 1);
    reset_mid();
    idle(4, 0, 32'd0);

    // Ten branches with three squash-separated misses, then read stats
    for (int i = 0; i < 10; i++) begin
      if (i == 2 || i == 5 || i == 8) begin
        bad(32'h6000 + 32'(i * 4), MW'(i), 0);
        idle(2, 0, 32'd0);
      end else begin
        good(32'h6000 + 32'(i * 4), MW'(i), 0);
      end
    end
    idle(3, 0, 32'd0);
    idle(1, 0, 32'd1);
    idle(1, 0, 32'd2);
    idle(1, 0, 32'd3);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      pc = $urandom & 32'hFFFF_FFFC;
      tk = 1'($urandom_range(0, 1));
      tg = tgs[$urandom_range(0, 3)];
      pd = ($urandom_range(0, 3) == 0) ? ~tk : tk;
      pt = ($urandom_range(0, 3) == 0) ? tgs[$urandom_range(0, 3)] : tg;
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 4) != 0), pc, tk, tg, pd, pt,
           MW'($urandom), ($urandom_range(0, 9) < 3), 32'($urandom_range(0, 3)));
    end

    idle(12, 0, 32'd0);
    @(negedge clk); #1;
    chk("drain_updates", 64'(q_upd.size()), 0);
    chk("drain_redirects", 64'(q_red.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
